pipe_scroller: RTL and testbench
================================

# pipe_scroller

Consumer of the 4-bit LFSR random stream in the Flappy datapath. It samples one random value per spawned obstacle and turns it into a pipe column with a gap on the 16x16 LED field. It scrolls the field one column per game tick, detects bird/pipe collision and counts pipes passed. Its outputs feed the LED display driver and the score display.

## Interface
- SPACING, 6, ticks between pipe spawns; legal range 2..15.
- GAP, 4, gap height in rows; legal range 1..15.
- BIRD_COL, 11, field column occupied by the bird; legal range 0..14.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion.
- tick  in  1  one-cycle scroll strobe from the game-rate divider.
- start  in  1  one-cycle pulse that begins or restarts a game.
- rand  in  4  current LFSR value.
- bird_row  in  4  bird row; 0 is the top row.
- pipes  out  256  packed [15:0][15:0] as [row][col]; 1 means a pipe pixel is lit. Column 0 is the right (entry) edge and column 15 is the left edge.
- score  out  8  pipes passed; saturates at 255.
- running  out  1  high in state RUN.
- game_over  out  1  high in state HALT.

## Operation
- States:
  - IDLE (reset state): field blank, waiting for start.
  - RUN: scrolling.
  - HALT: field and score frozen after a collision.
- IDLE or HALT with start=1 → RUN. On the same edge: pipes cleared, col_valid cleared, score cleared, spawn_cnt = SPACING-1.
- start is ignored in RUN. tick is ignored in IDLE and HALT.
- Internal col_valid[15:0] has one bit per column, set when that column holds a pipe.
- RUN with tick=1 and no collision this cycle:
  - Every row shifts one column left: col c takes col c-1, and col 15 is discarded. col_valid shifts the same way.
  - If spawn_cnt==0, col 0 is loaded with a pipe and col_valid[0]=1, then spawn_cnt=SPACING-1.
  - Otherwise col 0 is blank, col_valid[0]=0, and spawn_cnt decrements.
- Gap placement: gap_top = rand when rand ≤ 16-GAP, else rand-(16-GAP). Rows gap_top..gap_top+GAP-1 of col 0 are 0 and all other rows are 1. rand is sampled in the tick cycle only.
- Scoring: a tick shift with col_valid[BIRD_COL]=1 before the shift increments score by 1. score saturates at 255 and never wraps.
- Collision: hit = pipes[bird_row][BIRD_COL], evaluated combinationally every cycle in RUN from registered state.
  - hit=1 → HALT on the next edge.
  - Collision takes priority over a simultaneous tick: no shift, no spawn, no score.
- HALT holds pipes, score and col_valid until start or reset.

## Timing
- Reset values (immediate on reset=0, asynchronous):
  - state IDLE, running=0, game_over=0
  - pipes all 0, col_valid 0, score 0, spawn_cnt SPACING-1
- All outputs are registered.
- pipes and score reflect a tick on the edge ending the tick cycle, giving 1-cycle latency.
- After a start pulse in cycle N, running=1 from cycle N+1.
- The first pipe appears in col 0 on the SPACING-th accepted tick. Later pipes follow every SPACING ticks.
- A pipe reaches BIRD_COL BIRD_COL ticks after it spawns.
- Collision: hit in cycle N gives game_over=1 and running=0 from cycle N+1.
- Reset asserted mid-RUN clears everything within the same cycle with no edge needed. Release is synchronous to the next clock edge.
- tick held high for multiple cycles counts as one tick per cycle.

## Test plan
- Reset: pulse reset=0 mid-RUN → pipes=0, score=0, running=0, game_over=0 immediately, without a clock edge.
- Spawn: start, rand=5, bird_row=0, 6 ticks → col 0 has rows 0-4 and 9-15 set, rows 5-8 clear, and every other column is 0.
- Gap clamp: rand=14 at the spawn tick → gap rows 2-5 clear in col 0. rand=12 → rows 12-15 clear.
- Scoring: bird_row chosen inside every gap (rand held at 5, bird_row=6), 6+11+1 ticks → score=1 after the first pipe leaves col 11. score=2 six ticks later, and game_over stays 0.
- Collision with simultaneous tick: bird_row=0, pipe lands in col 11 → game_over=1 next cycle. A tick asserted in the hit cycle causes no shift, and pipes stay frozen for 20 more ticks.
- Restart and saturation: start while in HALT → field clear, score=0, running=1. Force the score to 255 via a long run → it stays at 255 after the next passed pipe.

Source files
------------

// File: rtl/pipe_scroller_if.sv
// pipe_scroller_if
// Groups the game-side signals of the pipe scroller into one bundle.
//   master : game controller / test side; drives tick, start, rand_value
//            and bird_row, and observes the field, score and status flags.
//   slave  : the pipe scroller itself.
// Signals:
//   tick       one-cycle scroll strobe from the game-rate divider
//   start      one-cycle pulse that begins or restarts a game
//   rand_value current 4-bit LFSR value
//   bird_row   bird row, 0 is the top row
//   pipes      [row][col] LED field, col 0 is the right (entry) edge
//   score      pipes passed, saturating at 255
//   running    high while the game is scrolling
//   game_over  high while the field is frozen after a collision
interface pipe_scroller_if;
  logic              tick;
  logic              start;
  logic [3:0]        rand_value;
  logic [3:0]        bird_row;
  logic [15:0][15:0] pipes;
  logic [7:0]        score;
  logic              running;
  logic              game_over;

  modport master (
    output tick, start, rand_value, bird_row,
    input  pipes, score, running, game_over
  );

  modport slave (
    input  tick, start, rand_value, bird_row,
    output pipes, score, running, game_over
  );
endinterface

// File: rtl/pipe_scroller.sv
// pipe_scroller
// Turns the LFSR stream into scrolling pipe columns on a 16x16 LED field,
// detects bird/pipe collision and counts pipes passed.
// Ports:
//   clock  system clock, all state changes on its rising edge
//   reset  asynchronous, active-low; clears all state immediately
//   bus    pipe_scroller_if.slave: tick, start, rand_value, bird_row in;
//          pipes, score, running, game_over out (all registered)
// Parameters:
//   SPACING  ticks between pipe spawns (2..15)
//   GAP      gap height in rows (1..15)
//   BIRD_COL field column occupied by the bird (0..14)
module pipe_scroller #(
  parameter int SPACING  = 6,
  parameter int GAP      = 4,
  parameter int BIRD_COL = 11
) (
  input logic          clock,
  input logic          reset,
  pipe_scroller_if.slave bus
);

  localparam logic [3:0] SPAWN_RELOAD = 4'(SPACING - 1);
  localparam logic [4:0] GAP_LIMIT    = 5'(16 - GAP);
  localparam logic [3:0] BIRD_IDX     = 4'(BIRD_COL);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state;
  state_t      next_state;

  // Column 15 is never inspected (the bird sits in col 14 at most), so
  // only columns 0..14 need a valid flag.
  logic [14:0] col_valid;
  logic [3:0]  spawn_cnt;
  logic [3:0]  gap_top;
  logic [15:0] new_col;
  logic        hit;
  logic        restart;
  logic        advance;
  logic        spawn;

  // Gap placement for a freshly spawned column. Random values that would
  // push the gap past the bottom row wrap back towards the top.
  always_comb begin
    gap_top = bus.rand_value;
    if ({1'b0, bus.rand_value} > GAP_LIMIT) begin
      gap_top = bus.rand_value - GAP_LIMIT[3:0];
    end
    new_col = '0;
    for (int r = 0; r < 16; r++) begin
      new_col[r] = !((r >= int'(gap_top)) && (r < int'(gap_top) + GAP));
    end
  end

  // A collision freezes the field, so it overrides a tick in the same cycle.
  always_comb begin
    hit     = (state == RUN) && bus.pipes[bus.bird_row][BIRD_IDX];
    restart = (state != RUN) && bus.start;
    advance = (state == RUN) && bus.tick && !hit;
    spawn   = advance && (spawn_cnt == 4'd0);
  end

  // State register; status flags are registered from the next state so
  // they line up with the state itself.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bus.running   <= 1'b0;
      bus.game_over <= 1'b0;
    end else begin
      state         <= next_state;
      bus.running   <= (next_state == RUN);
      bus.game_over <= (next_state == HALT);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (hit)       next_state = HALT;
      HALT:    if (bus.start) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  // Field, score and spawn countdown. Each row shifts towards col 15 on an
  // accepted tick; the pipe that was in the bird column before the shift
  // has just been passed and scores.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.pipes <= '0;
      bus.score <= '0;
      col_valid <= '0;
      spawn_cnt <= SPAWN_RELOAD;
    end else if (restart) begin
      bus.pipes <= '0;
      bus.score <= '0;
      col_valid <= '0;
      spawn_cnt <= SPAWN_RELOAD;
    end else if (advance) begin
      for (int r = 0; r < 16; r++) begin
        bus.pipes[r] <= {bus.pipes[r][14:0], spawn & new_col[r]};
      end
      col_valid <= {col_valid[13:0], spawn};
      if (col_valid[BIRD_IDX] && (bus.score != 8'hFF)) begin
        bus.score <= bus.score + 8'd1;
      end
      spawn_cnt <= spawn ? SPAWN_RELOAD : (spawn_cnt - 4'd1);
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller
// Drives pipe_scroller through spawn, gap wrap, collision, restart, async
// reset and score saturation. A pipe-list model (positions and gap tops)
// predicts the field, score and status every cycle; literal expectations
// pin the model at the interesting points.
module tb_pipe_scroller;

  localparam int SPACING  = 6;
  localparam int GAP      = 4;
  localparam int BIRD_COL = 11;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pipe_scroller_if bus();

  pipe_scroller #(
    .SPACING  (SPACING),
    .GAP      (GAP),
    .BIRD_COL (BIRD_COL)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: every pipe on the field is a position and a gap top.
  typedef struct {
    int pos;
    int gap;
  } pipe_t;

  pipe_t m_pipes[$];
  int    m_state = M_IDLE;
  int    m_score = 0;
  int    m_ticks = 0;

  logic       s_rst   = 1'b0;
  logic       s_tick  = 1'b0;
  logic       s_start = 1'b0;
  logic [3:0] s_rand  = '0;
  logic [3:0] s_row   = '0;

  function automatic int gap_of(int rv);
    return (rv <= 16 - GAP) ? rv : rv - (16 - GAP);
  endfunction

  function automatic logic [15:0][15:0] model_field();
    logic [15:0][15:0] f;
    f = '0;
    foreach (m_pipes[i]) begin
      for (int r = 0; r < 16; r++) begin
        if (r < m_pipes[i].gap || r >= m_pipes[i].gap + GAP) begin
          f[r][m_pipes[i].pos] = 1'b1;
        end
      end
    end
    return f;
  endfunction

  function automatic logic [255:0] field_with(int c, logic [15:0] v);
    logic [15:0][15:0] f;
    f = '0;
    for (int r = 0; r < 16; r++) f[r][c] = v[r];
    return f;
  endfunction

  task automatic check_output(input string name, input logic [255:0] act,
                              input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_col(input string name, input int c, input logic [15:0] exp);
    logic [15:0] act;
    for (int r = 0; r < 16; r++) act[r] = bus.pipes[r][c];
    check_output(name, {240'd0, act}, {240'd0, exp});
  endtask

  // Advance the model by the one clock edge that preceded this negedge.
  task automatic model_step();
    logic [15:0][15:0] f;
    pipe_t np;
    if (!reset || !s_rst) begin
      m_pipes.delete();
      m_state = M_IDLE;
      m_score = 0;
      m_ticks = 0;
    end else if (m_state != M_RUN) begin
      if (s_start) begin
        m_pipes.delete();
        m_state = M_RUN;
        m_score = 0;
        m_ticks = 0;
      end
    end else begin
      f = model_field();
      if (f[s_row][BIRD_COL]) begin
        m_state = M_HALT;
      end else if (s_tick) begin
        for (int i = m_pipes.size() - 1; i >= 0; i--) begin
          m_pipes[i].pos = m_pipes[i].pos + 1;
          if (m_pipes[i].pos == BIRD_COL + 1 && m_score < 255) m_score = m_score + 1;
          if (m_pipes[i].pos > 15) m_pipes.delete(i);
        end
        if (m_ticks % SPACING == SPACING - 1) begin
          np.pos = 0;
          np.gap = gap_of(int'(s_rand));
          m_pipes.push_back(np);
        end
        m_ticks = m_ticks + 1;
      end
    end
  endtask

  always @(posedge clock) begin
    s_rst   <= reset;
    s_tick  <= bus.tick;
    s_start <= bus.start;
    s_rand  <= bus.rand_value;
    s_row   <= bus.bird_row;
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clock) begin
    logic [15:0][15:0] exp_field;
    model_step();
    exp_field = model_field();
    check_output("model pipes", bus.pipes, exp_field);
    check_output("model score", {248'd0, bus.score}, {248'd0, 8'(m_score)});
    check_output("model running", {255'd0, bus.running}, {255'd0, m_state == M_RUN});
    check_output("model game_over", {255'd0, bus.game_over}, {255'd0, m_state == M_HALT});
  end

  task automatic apply_stimulus(input logic t, input logic s,
                                input logic [3:0] rv, input logic [3:0] row);
    @(negedge clock);
    bus.tick       = t;
    bus.start      = s;
    bus.rand_value = rv;
    bus.bird_row   = row;
  endtask

  task automatic do_ticks(input int n, input logic [3:0] rv, input logic [3:0] row);
    repeat (n) apply_stimulus(1'b1, 1'b0, rv, row);
  endtask

  task automatic idle(input logic [3:0] row);
    apply_stimulus(1'b0, 1'b0, 4'd0, row);
  endtask

  task automatic check_flags(input string name, input logic run, input logic over);
    check_output({name, " running"}, {255'd0, bus.running}, {255'd0, run});
    check_output({name, " game_over"}, {255'd0, bus.game_over}, {255'd0, over});
  endtask

  initial begin
    bus.tick       = 1'b0;
    bus.start      = 1'b0;
    bus.rand_value = 4'd0;
    bus.bird_row   = 4'd0;
    reset          = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset state
    check_output("reset pipes", bus.pipes, 256'd0);
    check_output("reset score", {248'd0, bus.score}, 256'd0);
    check_flags("reset", 1'b0, 1'b0);

    // First spawn with rand=5: gap rows 5..8
    apply_stimulus(1'b0, 1'b1, 4'd5, 4'd0);
    idle(4'd0);
    check_flags("start", 1'b1, 1'b0);
    do_ticks(6, 4'd5, 4'd0);
    idle(4'd0);
    check_col("spawn col0", 0, 16'hFE1F);
    check_output("spawn field", bus.pipes, field_with(0, 16'hFE1F));
    check_output("spawn score", {248'd0, bus.score}, 256'd0);

    // Second spawn with rand=14 wraps to gap rows 2..5
    do_ticks(5, 4'd5, 4'd0);
    do_ticks(1, 4'd14, 4'd0);
    idle(4'd0);
    check_col("clamp14 col0", 0, 16'hFFC3);
    check_col("clamp14 col6", 6, 16'hFE1F);

    // First pipe reaches col 11 with the bird in a lit row; the tick in the
    // hit cycle must not shift
    do_ticks(5, 4'd5, 4'd0);
    do_ticks(1, 4'd5, 4'd0);
    idle(4'd0);
    check_flags("collide", 1'b0, 1'b1);
    check_output("collide field", bus.pipes,
                 field_with(11, 16'hFE1F) | field_with(5, 16'hFFC3));
    do_ticks(20, 4'd5, 4'd0);
    idle(4'd0);
    check_output("frozen field", bus.pipes,
                 field_with(11, 16'hFE1F) | field_with(5, 16'hFFC3));
    check_output("frozen score", {248'd0, bus.score}, 256'd0);
    check_flags("frozen", 1'b0, 1'b1);

    // Restart from HALT
    apply_stimulus(1'b0, 1'b1, 4'd5, 4'd6);
    idle(4'd6);
    check_output("restart field", bus.pipes, 256'd0);
    check_output("restart score", {248'd0, bus.score}, 256'd0);
    check_flags("restart", 1'b1, 1'b0);

    // rand=12 sits exactly on the limit: gap rows 12..15
    do_ticks(6, 4'd12, 4'd6);
    idle(4'd6);
    check_output("clamp12 field", bus.pipes, field_with(0, 16'h0FFF));

    // Asynchronous reset mid-run, no clock edge in between
    #2 reset = 1'b0;
    #1;
    check_output("async pipes", bus.pipes, 256'd0);
    check_output("async score", {248'd0, bus.score}, 256'd0);
    check_flags("async", 1'b0, 1'b0);
    @(negedge clock);
    #2 reset = 1'b1;

    // Scoring with the bird inside every gap
    apply_stimulus(1'b0, 1'b1, 4'd5, 4'd6);
    do_ticks(18, 4'd5, 4'd6);
    idle(4'd6);
    check_output("score1", {248'd0, bus.score}, 256'd1);
    check_flags("score1", 1'b1, 1'b0);
    do_ticks(6, 4'd5, 4'd6);
    idle(4'd6);
    check_output("score2", {248'd0, bus.score}, 256'd2);

    // Saturation: score 254 at tick 1541, 255 at 1542, still 255 at 1548
    do_ticks(1517, 4'd5, 4'd6);
    idle(4'd6);
    check_output("score254", {248'd0, bus.score}, 256'd254);
    do_ticks(1, 4'd5, 4'd6);
    idle(4'd6);
    check_output("score255", {248'd0, bus.score}, 256'd255);
    do_ticks(6, 4'd5, 4'd6);
    idle(4'd6);
    check_output("score sat", {248'd0, bus.score}, 256'd255);
    check_flags("score sat", 1'b1, 1'b0);

    repeat (2) idle(4'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
